branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Fetch-side counterpart of the execute-stage branch comparator. It predicts B-type
//  branches (opcode 7'b1100011) at fetch using a table of 2-bit saturating counters.
//  It keeps each prediction in an in-order queue until the branch resolves.
//  It then checks the prediction against the resolved outcome and target from execute,
//  trains the counters, and issues a one-cycle PC redirect on a mispredict.
// PARAMETERS
//  XLEN        64   PC / target width
//  BHT_ENTRIES 64   counter-table entries, power of 2; IDX = log2(BHT_ENTRIES)
//  QDEPTH      4    in-flight prediction queue depth, power of 2
// PORTS
//  clk                 in   1     clock, rising edge
//  rst_n               in   1     synchronous active-low reset
//  bp_fetch_valid      in   1     fetch slot valid
//  bp_fetch_pc         in   XLEN  PC of fetched instruction
//  bp_fetch_instr      in   32    fetched instruction word
//  bp_fetch_ready      out  1     queue can accept a branch (count < QDEPTH)
//  bp_pred_taken       out  1     combinational prediction for current fetch slot
//  bp_pred_target      out  XLEN  combinational predicted target (pc + B-imm)
//  bp_resolve_valid    in   1     execute resolved the oldest in-flight branch
//  bp_resolve_taken    in   1     branch compare result
//  bp_resolve_target   in   XLEN  computed branch target from execute
//  bp_redirect_valid   out  1     registered 1-cycle pulse: mispredict
//  bp_redirect_pc      out  XLEN  correct next PC, valid with redirect_valid
//  bp_queue_empty      out  1     no unresolved branches in flight
// BEHAVIOUR
//  - is_br = instr[6:0]==7'b1100011 && funct3 in {000,001,100,101,110,111}.
//    Any other funct3 is not treated as a branch.
//  - idx = pc[IDX+1:2]. bp_pred_taken = fetch_valid & is_br & ctr[idx][1].
//  - bp_pred_target = pc + sext({i[31],i[7],i[30:25],i[11:8],1'b0}), computed mod 2^XLEN.
//  - Push: on fetch_valid & fetch_ready & is_br, enqueue {idx, pred_taken, pred_target,
//    pc+4}. Non-branches are never enqueued and do not depend on bp_fetch_ready.
//  - Pop: on resolve_valid with queue non-empty, dequeue the head.
//    A resolve_valid while empty is ignored: no update, no redirect.
//  - mispredict = head.pred_taken != resolve_taken ||
//    (resolve_taken && head.pred_target != resolve_target).
//  - Next cycle: redirect_valid=1 and redirect_pc = resolve_taken ? resolve_target : head.pc4.
//    Latency from resolve to redirect is 1 cycle.
//  - Train at the pop edge: taken -> ctr+1 saturating at 2'b11; not taken -> ctr-1
//    saturating at 2'b00.
//    A same-cycle fetch read of the same idx sees the pre-update value (no bypass).
//  - On a mispredict pop, all remaining entries are flushed. A push in that same cycle is
//    discarded, since it is on the wrong path. Count becomes 0.
//  - Push and pop in the same cycle without a mispredict: both occur and count is unchanged.
//    When full, fetch_ready=0 even if a pop is occurring this cycle.
//  - Head/tail pointers wrap modulo QDEPTH. Count is IDX_Q+1 bits wide.
//  - Reset (also mid-operation), checked at the clk edge with rst_n=0:
//    - all counters = 2'b01 (weakly not-taken); queue cleared;
//    - redirect_valid=0, redirect_pc=0, queue_empty=1, fetch_ready=1.
// CONFIGURATION
//  BP_STATS_EN defined:
//    - adds ports bp_stat_branches (out 32) and bp_stat_mispredicts (out 32), both reset to 0;
//    - branches increments on every valid pop;
//    - mispredicts increments on every mispredict pop;
//    - both wrap at 2^32.
//  BP_STATS_EN undefined: these ports and counters do not exist.
// TESTING
//  1 Reset, then fetch BEQ at pc=0x100 with imm=+16 -> pred_taken=0, pred_target=0x110.
//    Then resolve taken=1, target=0x110 -> redirect_valid pulses 1 cycle later with pc=0x110.
//    ctr becomes 2'b10.
//  2 Same BEQ resolved taken 3 more times -> ctr saturates at 2'b11 and pred_taken=1.
//    Then resolve not-taken -> redirect_pc=0x104 and ctr=2'b10.
//  3 Push 4 branches without resolving -> fetch_ready=0 and a 5th branch is not enqueued.
//    A non-branch ADDI still passes with no effect.
//  4 3 branches in flight, the oldest mispredicts -> queue_empty=1 next cycle.
//    A branch pushed in the same cycle is dropped, and the next 2 resolves produce no redirect.
//  5 Predicted-taken and resolved-taken, but resolve_target=0x200 != 0x110
//    -> redirect to 0x200; ctr increments.
//  6 Assert rst_n=0 mid-stream with 2 entries in flight -> queue empty, all counters 01,
//    and no redirect.
//    With BP_STATS_EN, both stats read 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-side B-type branch predictor: 2-bit counter table plus an in-order queue of
// in-flight predictions checked against execute. Optional stats ports via BP_STATS_EN.
module branch_predictor #(
    parameter int XLEN        = 64,
    parameter int BHT_ENTRIES = 64,
    parameter int QDEPTH      = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            bp_fetch_valid,
    input  logic [XLEN-1:0] bp_fetch_pc,
    input  logic [31:0]     bp_fetch_instr,
    output logic            bp_fetch_ready,
    output logic            bp_pred_taken,
    output logic [XLEN-1:0] bp_pred_target,
    input  logic            bp_resolve_valid,
    input  logic            bp_resolve_taken,
    input  logic [XLEN-1:0] bp_resolve_target,
    output logic            bp_redirect_valid,
    output logic [XLEN-1:0] bp_redirect_pc,
    output logic            bp_queue_empty
`ifdef BP_STATS_EN
    ,
    output logic [31:0]     bp_stat_branches,
    output logic [31:0]     bp_stat_mispredicts
`endif
);

    localparam int IDX   = $clog2(BHT_ENTRIES);
    localparam int IDX_Q = $clog2(QDEPTH);
    localparam logic [IDX_Q:0] Q_FULL = (IDX_Q+1)'(QDEPTH);

    // Handshake: a branch transfers into the queue when fetch_valid & fetch_ready & is_br
    // on a rising edge; a resolve transfers when resolve_valid and the queue is non-empty.

    logic [1:0]      ctr [BHT_ENTRIES];
    logic [IDX-1:0]  q_idx  [QDEPTH];
    logic            q_pred [QDEPTH];
    logic [XLEN-1:0] q_tgt  [QDEPTH];
    logic [XLEN-1:0] q_pc4  [QDEPTH];

    logic [IDX_Q-1:0] head, tail;
    logic [IDX_Q:0]   count;

    logic            is_br;
    logic [IDX-1:0]  fetch_idx;
    logic [12:0]     b_imm;
    logic [XLEN-1:0] b_off;
    logic            do_push, do_pop, mispredict;
    logic [IDX-1:0]  head_idx;
    logic [1:0]      head_ctr;
    logic            unused_instr_bits;

    assign unused_instr_bits = ^bp_fetch_instr[24:15];

    assign is_br = (bp_fetch_instr[6:0] == 7'b1100011) &&
                   (bp_fetch_instr[14:12] != 3'b010) && (bp_fetch_instr[14:12] != 3'b011);
    assign fetch_idx = bp_fetch_pc[IDX+1:2];
    assign b_imm = {bp_fetch_instr[31], bp_fetch_instr[7], bp_fetch_instr[30:25],
                    bp_fetch_instr[11:8], 1'b0};
    assign b_off = {{(XLEN-13){b_imm[12]}}, b_imm};

    assign bp_pred_target = bp_fetch_pc + b_off;
    assign bp_pred_taken  = bp_fetch_valid & is_br & ctr[fetch_idx][1];
    assign bp_fetch_ready = (count < Q_FULL);
    assign bp_queue_empty = (count == '0);

    assign do_push  = bp_fetch_valid & bp_fetch_ready & is_br;
    assign do_pop   = bp_resolve_valid & ~bp_queue_empty;
    assign head_idx = q_idx[head];
    assign head_ctr = ctr[head_idx];
    assign mispredict = do_pop &
        ((q_pred[head] != bp_resolve_taken) ||
         (bp_resolve_taken && (q_tgt[head] != bp_resolve_target)));

    // Pointer/count control; a mispredict flushes everything including a same-cycle push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (mispredict) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + IDX_Q'(1);
            if (do_pop)  head <= head + IDX_Q'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (IDX_Q+1)'(1);
                2'b01:   count <= count - (IDX_Q+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            q_idx[tail]  <= fetch_idx;
            q_pred[tail] <= bp_pred_taken;
            q_tgt[tail]  <= bp_pred_target;
            q_pc4[tail]  <= bp_fetch_pc + XLEN'(4);
        end
    end

    // Training happens at the pop edge, so a same-cycle fetch reads the old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) ctr[i] <= 2'b01;
        end else if (do_pop) begin
            if (bp_resolve_taken)
                ctr[head_idx] <= (head_ctr == 2'b11) ? 2'b11 : head_ctr + 2'b01;
            else
                ctr[head_idx] <= (head_ctr == 2'b00) ? 2'b00 : head_ctr - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bp_redirect_valid <= 1'b0;
            bp_redirect_pc    <= '0;
        end else begin
            bp_redirect_valid <= mispredict;
            if (mispredict)
                bp_redirect_pc <= bp_resolve_taken ? bp_resolve_target : q_pc4[head];
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bp_stat_branches    <= '0;
            bp_stat_mispredicts <= '0;
        end else begin
            if (do_pop)     bp_stat_branches    <= bp_stat_branches + 32'd1;
            if (mispredict) bp_stat_mispredicts <= bp_stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: decode table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_branch_predictor;

    localparam int XLEN = 64;
    localparam logic [31:0] BEQ16 = 32'h0000_0863;
    localparam logic [31:0] ADDI  = 32'h0010_0093;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            bp_fetch_valid;
    logic [XLEN-1:0] bp_fetch_pc;
    logic [31:0]     bp_fetch_instr;
    logic            bp_fetch_ready;
    logic            bp_pred_taken;
    logic [XLEN-1:0] bp_pred_target;
    logic            bp_resolve_valid;
    logic            bp_resolve_taken;
    logic [XLEN-1:0] bp_resolve_target;
    logic            bp_redirect_valid;
    logic [XLEN-1:0] bp_redirect_pc;
    logic            bp_queue_empty;
`ifdef BP_STATS_EN
    logic [31:0]     bp_stat_branches;
    logic [31:0]     bp_stat_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk(clk), .rst_n(rst_n),
        .bp_fetch_valid(bp_fetch_valid), .bp_fetch_pc(bp_fetch_pc),
        .bp_fetch_instr(bp_fetch_instr), .bp_fetch_ready(bp_fetch_ready),
        .bp_pred_taken(bp_pred_taken), .bp_pred_target(bp_pred_target),
        .bp_resolve_valid(bp_resolve_valid), .bp_resolve_taken(bp_resolve_taken),
        .bp_resolve_target(bp_resolve_target),
        .bp_redirect_valid(bp_redirect_valid), .bp_redirect_pc(bp_redirect_pc),
        .bp_queue_empty(bp_queue_empty)
`ifdef BP_STATS_EN
        , .bp_stat_branches(bp_stat_branches), .bp_stat_mispredicts(bp_stat_mispredicts)
`endif
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [5:0]  idx;
        logic        pred;
        logic [63:0] tgt;
        logic [63:0] pc4;
    } ent_t;

    ent_t        exp_q[$];
    int          ctr_m [64];
    logic        exp_rv;
    logic [63:0] exp_rpc;
    int unsigned stat_br_m, stat_mis_m;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic model_is_br(logic [31:0] ins);
        return (ins[6:0] == 7'h63) && !(ins[14:12] inside {3'd2, 3'd3});
    endfunction

    function automatic logic [63:0] model_target(logic [63:0] pc, logic [31:0] ins);
        longint off;
        off = ins[11:8] * 2 + ins[30:25] * 32 + ins[7] * 2048;
        if (ins[31]) off = off - 4096;
        return pc + 64'(off);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs, let them settle, compare every visible output with the model.
    task automatic drive(logic fv, logic [63:0] pc, logic [31:0] ins,
                         logic rv, logic rt, logic [63:0] rtgt);
        logic exp_pred;
        bp_fetch_valid    = fv;
        bp_fetch_pc       = pc;
        bp_fetch_instr    = ins;
        bp_resolve_valid  = rv;
        bp_resolve_taken  = rt;
        bp_resolve_target = rtgt;
        #1;
        exp_pred = fv && model_is_br(ins) && (ctr_m[pc[7:2]] >= 2);
        check("pred_taken", {63'd0, bp_pred_taken}, {63'd0, exp_pred});
        check("pred_target", bp_pred_target, model_target(pc, ins));
        check("fetch_ready", {63'd0, bp_fetch_ready}, {63'd0, exp_q.size() < 4});
        check("queue_empty", {63'd0, bp_queue_empty}, {63'd0, exp_q.size() == 0});
        check("redirect_valid", {63'd0, bp_redirect_valid}, {63'd0, exp_rv});
        if (exp_rv) check("redirect_pc", bp_redirect_pc, exp_rpc);
`ifdef BP_STATS_EN
        check("stat_branches", {32'd0, bp_stat_branches}, {32'd0, stat_br_m});
        check("stat_mispredicts", {32'd0, bp_stat_mispredicts}, {32'd0, stat_mis_m});
`endif
    endtask

    task automatic tick();
        logic  br, push, pred, mis;
        ent_t  h;
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) ctr_m[i] = 1;
            exp_q.delete();
            exp_rv = 1'b0; exp_rpc = '0;
            stat_br_m = 0; stat_mis_m = 0;
        end else begin
            br   = bp_fetch_valid && model_is_br(bp_fetch_instr);
            push = br && (exp_q.size() < 4);
            pred = br && (ctr_m[bp_fetch_pc[7:2]] >= 2);
            mis  = 1'b0;
            exp_rv = 1'b0;
            if (bp_resolve_valid && exp_q.size() > 0) begin
                h = exp_q.pop_front();
                mis = (h.pred != bp_resolve_taken) ||
                      (bp_resolve_taken && h.tgt != bp_resolve_target);
                if (bp_resolve_taken) ctr_m[h.idx] = (ctr_m[h.idx] == 3) ? 3 : ctr_m[h.idx] + 1;
                else                  ctr_m[h.idx] = (ctr_m[h.idx] == 0) ? 0 : ctr_m[h.idx] - 1;
                stat_br_m++;
                if (mis) begin
                    stat_mis_m++;
                    exp_q.delete();
                    exp_rv  = 1'b1;
                    exp_rpc = bp_resolve_taken ? bp_resolve_target : h.pc4;
                end
            end
            if (push && !mis)
                exp_q.push_back('{bp_fetch_pc[7:2], pred,
                                  model_target(bp_fetch_pc, bp_fetch_instr), bp_fetch_pc + 64'd4});
        end
        @(negedge clk);
    endtask

    task automatic cyc(logic fv, logic [63:0] pc, logic [31:0] ins,
                       logic rv, logic rt, logic [63:0] rtgt);
        drive(fv, pc, ins, rv, rt, rtgt);
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    // ---------------- decode table ----------------
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        is_br;
        logic [63:0] tgt;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [31:0] r32;
        logic [63:0] pc_r, tgt_r;
        logic [31:0] ins_r;
        logic        rv_r, rt_r, fv_r;

        vecs[0] = '{64'h100, BEQ16,        1'b1, 64'h110};
        vecs[1] = '{64'h200, 32'hFE001EE3, 1'b1, 64'h1FC};
        vecs[2] = '{64'h300, 32'h00002863, 1'b0, 64'h310};
        vecs[3] = '{64'h040, 32'h00003863, 1'b0, 64'h050};
        vecs[4] = '{64'h000, 32'h00004863, 1'b1, 64'h010};
        vecs[5] = '{64'h1000, 32'h000070E3, 1'b1, 64'h1800};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFF0, BEQ16, 1'b1, 64'h0};
        vecs[7] = '{64'h500, ADDI,         1'b0, 64'hD00};

        rst_n = 1'b0;
        bp_fetch_valid = 0; bp_fetch_pc = 0; bp_fetch_instr = 0;
        bp_resolve_valid = 0; bp_resolve_taken = 0; bp_resolve_target = 0;
        tick();
        rst_n = 1'b1;
        check("reset_redirect_pc", bp_redirect_pc, 64'h0);
        check("reset_fetch_ready", {63'd0, bp_fetch_ready}, 64'd1);

        for (int i = 0; i < 8; i++) begin
            drive(1, vecs[i].pc, vecs[i].instr, 0, 0, 0);
            check("tbl_target", bp_pred_target, vecs[i].tgt);
            check("tbl_pred", {63'd0, bp_pred_taken}, 64'd0);
            tick();
            check("tbl_enqueued", {63'd0, bp_queue_empty}, {63'd0, !vecs[i].is_br});
            cyc(0, 0, 0, vecs[i].is_br, 0, 0);
            check("tbl_no_redirect", {63'd0, bp_redirect_valid}, 64'd0);
        end

        // First prediction is weakly not-taken; taken resolve redirects one cycle later.
        do_reset();
        drive(1, 64'h100, BEQ16, 0, 0, 0);
        check("t1_pred", {63'd0, bp_pred_taken}, 64'd0);
        check("t1_target", bp_pred_target, 64'h110);
        tick();
        cyc(0, 0, 0, 1, 1, 64'h110);
        check("t1_redir_v", {63'd0, bp_redirect_valid}, 64'd1);
        check("t1_redir_pc", bp_redirect_pc, 64'h110);
        cyc(0, 0, 0, 0, 0, 0);
        check("t1_pulse_end", {63'd0, bp_redirect_valid}, 64'd0);

        // Saturate to strongly taken, then a not-taken resolve falls back to pc+4.
        for (int k = 0; k < 3; k++) begin
            drive(1, 64'h100, BEQ16, 0, 0, 0);
            check("t2_pred_taken", {63'd0, bp_pred_taken}, 64'd1);
            tick();
            cyc(0, 0, 0, 1, 1, 64'h110);
            check("t2_no_redirect", {63'd0, bp_redirect_valid}, 64'd0);
        end
        cyc(1, 64'h100, BEQ16, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        check("t2_redir_v", {63'd0, bp_redirect_valid}, 64'd1);
        check("t2_redir_pc", bp_redirect_pc, 64'h104);

        // Correct direction, wrong target: redirect to execute's target and train up.
        drive(1, 64'h100, BEQ16, 0, 0, 0);
        check("t5_pred", {63'd0, bp_pred_taken}, 64'd1);
        tick();
        cyc(0, 0, 0, 1, 1, 64'h200);
        check("t5_redir_v", {63'd0, bp_redirect_valid}, 64'd1);
        check("t5_redir_pc", bp_redirect_pc, 64'h200);
        cyc(1, 64'h100, BEQ16, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        drive(1, 64'h100, BEQ16, 0, 0, 0);
        check("t5_ctr_was_11", {63'd0, bp_pred_taken}, 64'd1);
        tick();

        // Fill the queue; a 5th branch is refused and an ADDI has no effect.
        do_reset();
        for (int k = 0; k < 4; k++) cyc(1, 64'h400 + 64'(4 * k), BEQ16, 0, 0, 0);
        check("t3_full", {63'd0, bp_fetch_ready}, 64'd0);
        cyc(1, 64'h500, BEQ16, 0, 0, 0);
        cyc(1, 64'h504, ADDI, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, 0, 0);
        check("t3_drained", {63'd0, bp_queue_empty}, 64'd1);

        // Oldest of 3 mispredicts: flush, same-cycle push dropped, later resolves ignored.
        do_reset();
        for (int k = 0; k < 3; k++) cyc(1, 64'h600 + 64'(4 * k), BEQ16, 0, 0, 0);
        cyc(1, 64'h700, BEQ16, 1, 1, 64'h610);
        check("t4_empty", {63'd0, bp_queue_empty}, 64'd1);
        check("t4_redir_pc", bp_redirect_pc, 64'h610);
        for (int k = 0; k < 2; k++) begin
            cyc(0, 0, 0, 1, 0, 0);
            check("t4_no_redirect", {63'd0, bp_redirect_valid}, 64'd0);
        end

        // Mid-stream reset with 2 in flight and a trained counter.
        cyc(1, 64'h100, BEQ16, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 64'h110);
        cyc(1, 64'h100, BEQ16, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 64'h110);
        cyc(1, 64'h100, BEQ16, 0, 0, 0);
        cyc(1, 64'h104, BEQ16, 0, 0, 0);
        rst_n = 1'b0;
        cyc(1, 64'h100, BEQ16, 1, 1, 64'h999);
        rst_n = 1'b1;
        check("t6_empty", {63'd0, bp_queue_empty}, 64'd1);
        check("t6_ready", {63'd0, bp_fetch_ready}, 64'd1);
        check("t6_no_redirect", {63'd0, bp_redirect_valid}, 64'd0);
        check("t6_redir_pc", bp_redirect_pc, 64'h0);
        drive(1, 64'h100, BEQ16, 0, 0, 0);
        check("t6_ctr_01", {63'd0, bp_pred_taken}, 64'd0);
`ifdef BP_STATS_EN
        check("t6_stat_br", {32'd0, bp_stat_branches}, 64'd0);
        check("t6_stat_mis", {32'd0, bp_stat_mispredicts}, 64'd0);
`endif
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            fv_r  = ($urandom_range(0, 9) < 7);
            pc_r  = 64'h1000 + 64'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) pc_r = {$urandom, $urandom} & ~64'h3;
            r32   = $urandom;
            ins_r = r32;
            ins_r[6:0] = ($urandom_range(0, 4) != 0) ? 7'h63 : 7'h13;
            rv_r  = ($urandom_range(0, 9) < 4);
            rt_r  = $urandom_range(0, 1);
            if (exp_q.size() > 0 && $urandom_range(0, 3) != 0) tgt_r = exp_q[0].tgt;
            else tgt_r = {$urandom, $urandom};
            cyc(fv_r, pc_r, ins_r, rv_r, rt_r, tgt_r);
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
